// File: rtl/bell_ring_ctrl.sv
// Alarm bell sequencer: rings on an hh:mm:00 alarm match and stops on StopKey or when the burst runs out.
// Define BELL_RING_CTRL_SNOOZE_EN to build in the snooze state and the snooze counting.
module bell_ring_ctrl #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       EN,
    input  logic       SecTick,
    input  logic       BellEn,
    input  logic       SetBellMode,
    input  logic [3:0] CurHouh,
    input  logic [3:0] CurHoul,
    input  logic [3:0] CurMinh,
    input  logic [3:0] CurMinl,
    input  logic [3:0] CurSech,
    input  logic [3:0] CurSecl,
    input  logic [3:0] BelHouh,
    input  logic [3:0] BelHoul,
    input  logic [3:0] BelMinh,
    input  logic [3:0] BelMinl,
    input  logic       SnoozeKey,
    input  logic       StopKey,
    output logic       BellOut,
    output logic       Ringing,
    output logic       Snoozing,
    output logic [1:0] SnoozeCnt
);

    localparam int RingW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
    localparam logic [RingW-1:0] RingLast = RingW'(RING_SECS - 1);

`ifdef BELL_RING_CTRL_SNOOZE_EN
    localparam int SnzW = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;
    localparam logic [SnzW-1:0] SnzLast = SnzW'(SNOOZE_SECS - 1);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} stateType;
    logic [SnzW-1:0] snzCnt;
`else
    typedef enum logic [1:0] {IDLE, RING} stateType;
    logic unusedSnooze;
    assign unusedSnooze = SnoozeKey ^ (SNOOZE_SECS > 0) ^ (MAX_SNOOZE > 0);
`endif

    stateType         state;
    logic [RingW-1:0] ringCnt;
    logic             ringPhase;
    logic             alarmMatch;
    logic             ringDone;
    logic             snzStop;
    logic             toIdle;

    // Every path back to IDLE is gathered here so the register block has a single idle branch.
    always_comb begin
        alarmMatch = SecTick && (CurSech == 4'd0) && (CurSecl == 4'd0)
                     && ({CurHouh, CurHoul, CurMinh, CurMinl} == {BelHouh, BelHoul, BelMinh, BelMinl});
        ringDone   = SecTick && (ringCnt == RingLast);
`ifdef BELL_RING_CTRL_SNOOZE_EN
        snzStop    = SnoozeKey && (SnoozeCnt >= 2'(MAX_SNOOZE));
`else
        snzStop    = 1'b0;
`endif
        toIdle     = SetBellMode || !BellEn
                     || (EN && (state == RING) && (StopKey || snzStop || ringDone));
`ifdef BELL_RING_CTRL_SNOOZE_EN
        toIdle     = toIdle || (EN && (state == SNOOZE) && StopKey);
`endif
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state     <= IDLE;
            ringCnt   <= '0;
            ringPhase <= 1'b0;
            BellOut   <= 1'b0;
            Ringing   <= 1'b0;
            Snoozing  <= 1'b0;
            SnoozeCnt <= '0;
`ifdef BELL_RING_CTRL_SNOOZE_EN
            snzCnt    <= '0;
`endif
        end else if (toIdle) begin
            state     <= IDLE;
            ringCnt   <= '0;
            ringPhase <= 1'b0;
            BellOut   <= 1'b0;
            Ringing   <= 1'b0;
            Snoozing  <= 1'b0;
            SnoozeCnt <= '0;
        end else if (!EN) begin
            BellOut <= 1'b0;
        end else begin
            // ringPhase survives an EN pause so the bell resumes in step with the ring count
            BellOut <= (state == RING) && ringPhase;
            case (state)
                IDLE: begin
                    if (alarmMatch) begin
                        state     <= RING;
                        Ringing   <= 1'b1;
                        ringCnt   <= '0;
                        ringPhase <= 1'b1;
                        BellOut   <= 1'b1;
                    end
                end
                RING: begin
`ifdef BELL_RING_CTRL_SNOOZE_EN
                    if (SnoozeKey) begin
                        state     <= SNOOZE;
                        Ringing   <= 1'b0;
                        Snoozing  <= 1'b1;
                        SnoozeCnt <= SnoozeCnt + 2'd1;
                        snzCnt    <= '0;
                        ringPhase <= 1'b0;
                        BellOut   <= 1'b0;
                    end else
`endif
                    if (SecTick) begin
                        ringCnt   <= ringCnt + 1'b1;
                        ringPhase <= ~ringPhase;
                        BellOut   <= ~ringPhase;
                    end
                end
`ifdef BELL_RING_CTRL_SNOOZE_EN
                SNOOZE: begin
                    if (SecTick) begin
                        if (snzCnt == SnzLast) begin
                            state     <= RING;
                            Snoozing  <= 1'b0;
                            Ringing   <= 1'b1;
                            ringCnt   <= '0;
                            ringPhase <= 1'b1;
                            BellOut   <= 1'b1;
                        end else begin
                            snzCnt <= snzCnt + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    Ringing  <= 1'b0;
                    Snoozing <= 1'b0;
                end
            endcase
        end
    end

endmodule
